// File: rtl/aer_pkg.sv
// Shared types for the AER receiver: link address width, handshake FSM states, address type.
package aer_pkg;
   localparam int AER_ADDR_W = 10;

   typedef enum logic {IDLE, ACK_HI} aer_rx_state_t;

   typedef logic [AER_ADDR_W-1:0] aer_addr_t;
endpackage

// File: rtl/aer_rx_fifo.sv
// First-word-fall-through event FIFO with registered valid, head and level outputs.
// A same-cycle pop never frees a slot for a push; writes are gated by the current full flag.
module aer_rx_fifo
   import aer_pkg::*;
#(
   parameter  int W     = AER_ADDR_W,
   parameter  int DEPTH = 4,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic             valid,
   output logic [W-1:0]     head,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             valid_nxt
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [LVL_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic             wr_en, rd_en;
   logic [W-1:0]     head_nxt;

   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                  (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign wr_en = push & ~full;
   assign rd_en = pop & valid;

   assign wr_nxt    = wr_en ? wr_ptr + LVL_W'(1) : wr_ptr;
   assign rd_nxt    = rd_en ? rd_ptr + LVL_W'(1) : rd_ptr;
   assign valid_nxt = (wr_nxt != rd_nxt);

   // The next head is the incoming word only when it lands in the slot the read pointer moves to.
   assign head_nxt = (wr_en && (wr_ptr[IDX_W-1:0] == rd_nxt[IDX_W-1:0])) ? din
                                                                         : mem[rd_nxt[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         level  <= wr_nxt - rd_nxt;
         valid  <= valid_nxt;
         if (valid_nxt) head <= head_nxt;
      end
   end
endmodule

// File: rtl/aer_rx.sv
// AER link receiver: REQ synchroniser, 4-phase ACK handshake FSM and event FIFO to the core.
// Optional event counter built when AER_RX_STATS_EN is defined.
//   state  | meaning
//   IDLE   | ACK low, waiting for synchronised REQ and a free FIFO slot
//   ACK_HI | event pushed, ACK high until synchronised REQ falls
module aer_rx
   import aer_pkg::*;
#(
   parameter  int ADDR_W      = AER_ADDR_W,
   parameter  int FIFO_DEPTH  = 4,
   parameter  int SYNC_STAGES = 2,
`ifdef AER_RX_STATS_EN
   parameter  int CNT_W       = 16,
`endif
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              aerin_req,
   input  logic [ADDR_W-1:0] aerin_addr,
   output logic              aerin_ack,
   output logic              evt_valid,
   output logic [ADDR_W-1:0] evt_addr,
   input  logic              evt_ready,
   output logic              aerin_rx_busy,
`ifdef AER_RX_STATS_EN
   output logic [CNT_W-1:0]  evt_count,
`endif
   output logic [LVL_W-1:0]  fifo_level
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   req_s;
   logic                   full, valid_nxt, push;
   aer_rx_state_t          state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], aerin_req};
   end

   assign req_s = sync[SYNC_STAGES-1];
   // Address is bundled with REQ, so it is stable by the time req_s is seen high.
   assign push  = (state == IDLE) & req_s & ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         aerin_ack     <= 1'b0;
         aerin_rx_busy <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (push) begin
               state     <= ACK_HI;
               aerin_ack <= 1'b1;
            end
            ACK_HI: if (!req_s) begin
               state     <= IDLE;
               aerin_ack <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               aerin_ack <= 1'b0;
            end
         endcase
         aerin_rx_busy <= ((state == IDLE) ? push : req_s) | valid_nxt;
      end
   end

   aer_rx_fifo #(
      .W     (ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .din       (aerin_addr),
      .pop       (evt_ready),
      .valid     (evt_valid),
      .head      (evt_addr),
      .level     (fifo_level),
      .full      (full),
      .valid_nxt (valid_nxt)
   );

`ifdef AER_RX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      evt_count <= '0;
      else if (push && evt_count != '1) evt_count <= evt_count + CNT_W'(1);
   end
`endif
endmodule
